// File: rtl/conv_encoder_packetizer_pkg.sv
// Shared constants, FSM encoding and code-pair helper for the K=3 rate-1/2 encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_encoder_packetizer_pkg;

   localparam int VITERBI_K      = 3;
   localparam int VITERBI_PAIRS  = 8;
   localparam int VITERBI_WORD_W = 2 * VITERBI_PAIRS;

   // Default generators, taps ordered {u, s1, s2}
   localparam logic [VITERBI_K-1:0] G0_DEFAULT = 3'b111;
   localparam logic [VITERBI_K-1:0] G1_DEFAULT = 3'b101;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ENCODE = 1'b1
   } enc_state_t;

   // One code pair: bit [1] from g0, bit [0] from g1
   function automatic logic [1:0] conv_pair(
      input logic [VITERBI_K-1:0] g0,
      input logic [VITERBI_K-1:0] g1,
      input logic                 u,
      input logic                 s1,
      input logic                 s2
   );
      logic [VITERBI_K-1:0] taps;
      taps = {u, s1, s2};
      return {^(g0 & taps), ^(g1 & taps)};
   endfunction

endpackage

// File: rtl/conv_encoder_packetizer_sync_fifo.sv
// Generic single-clock FIFO with registered storage and raw head-of-queue read.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: pushes while full (without a same-cycle pop) and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage write; contents need no reset since empty gates their use
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/conv_encoder_packetizer.sv
// Rate-1/2 K=3 convolutional encoder: one byte in, one 16-bit coded word queued out.
// Latency: accept at edge T, word pushed at edge T+8, next accept possible at edge T+9.
// Backpressure: msg_ready drops while encoding or when the output FIFO is full (space reserved at accept).
module conv_encoder_packetizer
   import conv_encoder_packetizer_pkg::*;
#(
   parameter int         DEPTH = 2,
   parameter logic [2:0] G0    = G0_DEFAULT,
   parameter logic [2:0] G1    = G1_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                msg_in,
   input  logic                      msg_valid,
   output logic                      msg_ready,
   output logic [VITERBI_WORD_W-1:0] code_out,
   output logic                      code_valid,
   input  logic                      code_ready,
   output logic                      busy
);

   localparam int         CW       = $clog2(DEPTH + 1);
   localparam logic [2:0] LAST_IDX = 3'(VITERBI_PAIRS - 1);

   enc_state_t                state_q;
   enc_state_t                state_d;
   logic [2:0]                idx_q;
   logic                      s1_q;
   logic                      s2_q;
   logic [7:0]                msg_q;
   logic [VITERBI_WORD_W-1:0] word_q;

   logic                      accept;
   logic                      enc_push;
   logic                      u;
   logic [1:0]                pair;
   logic [VITERBI_WORD_W-1:0] word_next;

   logic [VITERBI_WORD_W-1:0] fifo_head;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [CW-1:0]             fifo_count;
   logic                      fifo_pop;

   // Current code pair; word fills from the top so pair 0 ends up in [1:0] after 8 shifts
   assign u         = msg_q[idx_q];
   assign pair      = conv_pair(G0, G1, u, s1_q, s2_q);
   assign word_next = {pair, word_q[VITERBI_WORD_W-1:2]};
   assign accept    = msg_valid && msg_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state, accept and push decode; no accept possible in the push cycle since state is ENCODE
   always_comb begin
      state_d   = state_q;
      msg_ready = 1'b0;
      enc_push  = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            msg_ready = !rst && !fifo_full;
            if (msg_valid && msg_ready) state_d = ST_ENCODE;
         end
         ST_ENCODE: begin
            busy = 1'b1;
            if (idx_q == LAST_IDX) begin
               enc_push = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift register, bit index and word assembly; every packet restarts from the zero state
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         msg_q  <= '0;
         word_q <= '0;
      end else if (accept) begin
         idx_q  <= '0;
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         msg_q  <= msg_in;
         word_q <= '0;
      end else if (state_q == ST_ENCODE) begin
         idx_q  <= idx_q + 3'd1;
         s2_q   <= s1_q;
         s1_q   <= u;
         word_q <= word_next;
      end
   end

   assign fifo_pop   = code_valid && code_ready;
   assign code_valid = (fifo_count != '0);
   assign code_out   = fifo_empty ? '0 : fifo_head;

   sync_fifo #(
      .WIDTH (VITERBI_WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (enc_push),
      .push_data (word_next),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_conv_encoder_packetizer.sv
// Directed bench for the convolutional encoder/packetizer.
// Latency: checks accept-to-valid timing of 8 edges and back-to-back accept spacing.
// Backpressure: exercises FIFO full stall, drain order and simultaneous push/pop.
module tb_conv_encoder_packetizer;

   logic        clk;
   logic        rst;
   logic [7:0]  msg_in;
   logic        msg_valid;
   logic        msg_ready;
   logic [15:0] code_out;
   logic        code_valid;
   logic        code_ready;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   conv_encoder_packetizer #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .msg_in     (msg_in),
      .msg_valid  (msg_valid),
      .msg_ready  (msg_ready),
      .code_out   (code_out),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required <200000", $time);
      $fatal(1, "watchdog");
   end

   // Present a byte from a negedge until taken; returns at the negedge after the accept edge
   task automatic offer(input logic [7:0] b, output int waited, output bit ok);
      waited = 0;
      msg_in = b;
      msg_valid = 1'b1;
      while (!msg_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      ok = msg_ready;
      @(posedge clk);
      @(negedge clk);
      msg_valid = 1'b0;
   endtask

   // Wait (bounded) at negedges for a valid word
   task automatic wait_word(output logic [15:0] w, output int cyc, output bit got);
      cyc = 0;
      while (!code_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      got = code_valid;
      w = code_out;
   endtask

   task automatic pop_one();
      code_ready = 1'b1;
      @(negedge clk);
      code_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; msg_valid = 1'b0; msg_in = '0; code_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_msg_ready_in_reset: got %b want 0", msg_ready); end
      n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL reset_code_valid: got %b want 0", code_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (msg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_msg_ready_after: got %b want 1", msg_ready); end
      n_cmp++; if (code_out !== 16'h0000) begin n_bad++; $display("FAIL reset_code_out: got %h want 0000", code_out); end
   endtask

   task automatic test_impulse();
      int w; bit ok; logic [15:0] word; int cyc; bit got;
      code_ready = 1'b1;
      offer(8'h01, w, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL impulse_accept: got %b want 1", ok); end
      n_cmp++; if (busy !== 1'b1 || msg_ready !== 1'b0) begin n_bad++; $display("FAIL impulse_busy: got busy=%b rdy=%b want 1/0", busy, msg_ready); end
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL impulse_timeout: got valid=%b want 1", got); end
      n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL impulse_latency: got %0d want 8", cyc); end
      n_cmp++; if (word !== 16'h003B) begin n_bad++; $display("FAIL impulse_word: got %h want 003b", word); end
      n_cmp++; if (msg_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL impulse_ready_again: got rdy=%b busy=%b want 1/0", msg_ready, busy); end
      @(negedge clk);
      n_cmp++; if (code_valid !== 1'b0 || code_out !== 16'h0000) begin n_bad++; $display("FAIL impulse_one_cycle: got v=%b d=%h want 0/0000", code_valid, code_out); end
   endtask

   task automatic test_ones_zero();
      int w; bit ok; logic [15:0] word; int cyc; bit got;
      code_ready = 1'b1;
      offer(8'hFF, w, ok);
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'hAAA7) begin n_bad++; $display("FAIL ones_word: got v=%b d=%h want 1/aaa7", got, word); end
      offer(8'h00, w, ok);
      n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL zero_accept_gap: got %0d want 0", w); end
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'h0000) begin n_bad++; $display("FAIL zero_word: got v=%b d=%h want 1/0000", got, word); end
      @(negedge clk);
      n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL zero_drained: got %b want 0", code_valid); end
   endtask

   task automatic test_back_to_back();
      int w1, w2; bit ok; logic [15:0] word; int cyc; bit got;
      code_ready = 1'b0;
      offer(8'h80, w1, ok);
      offer(8'h01, w2, ok);
      n_cmp++; if (w2 !== 8) begin n_bad++; $display("FAIL b2b_accept_gap: got %0d want 8", w2); end
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'hC000) begin n_bad++; $display("FAIL b2b_first_word: got v=%b d=%h want 1/c000", got, word); end
      pop_one();
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'h003B) begin n_bad++; $display("FAIL b2b_second_word: got v=%b d=%h want 1/003b", got, word); end
      pop_one();
      n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", code_valid); end
   endtask

   task automatic test_backpressure();
      int w; bit ok; logic [15:0] word; int cyc; bit got;
      code_ready = 1'b0;
      offer(8'h01, w, ok);
      offer(8'hFF, w, ok);
      msg_in = 8'h80; msg_valid = 1'b1;
      repeat (12) @(negedge clk);
      n_cmp++; if (msg_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got rdy=%b busy=%b want 0/0", msg_ready, busy); end
      n_cmp++; if (code_valid !== 1'b1 || code_out !== 16'h003B) begin n_bad++; $display("FAIL bp_head0: got v=%b d=%h want 1/003b", code_valid, code_out); end
      code_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (code_out !== 16'hAAA7 || msg_ready !== 1'b1) begin n_bad++; $display("FAIL bp_head1: got d=%h rdy=%b want aaa7/1", code_out, msg_ready); end
      @(negedge clk);
      msg_valid = 1'b0;
      n_cmp++; if (code_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL bp_third_accepted: got v=%b busy=%b want 0/1", code_valid, busy); end
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'hC000 || cyc !== 8) begin n_bad++; $display("FAIL bp_third_word: got v=%b d=%h cyc=%0d want 1/c000/8", got, word, cyc); end
      offer(8'h00, w, ok);
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'h0000) begin n_bad++; $display("FAIL bp_fourth_word: got v=%b d=%h want 1/0000", got, word); end
      @(negedge clk);
      code_ready = 1'b0;
      n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", code_valid); end
   endtask

   task automatic test_push_pop();
      int w; bit ok; logic [15:0] word; int cyc; bit got;
      code_ready = 1'b0;
      offer(8'h01, w, ok);
      wait_word(word, cyc, got);
      offer(8'hFF, w, ok);
      repeat (7) @(negedge clk);
      n_cmp++; if (code_out !== 16'h003B || busy !== 1'b1) begin n_bad++; $display("FAIL pp_before: got d=%h busy=%b want 003b/1", code_out, busy); end
      code_ready = 1'b1;
      @(negedge clk);
      code_ready = 1'b0;
      n_cmp++; if (code_valid !== 1'b1 || code_out !== 16'hAAA7) begin n_bad++; $display("FAIL pp_after: got v=%b d=%h want 1/aaa7", code_valid, code_out); end
      n_cmp++; if (msg_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL pp_count_one: got rdy=%b busy=%b want 1/0", msg_ready, busy); end
      @(negedge clk);
      n_cmp++; if (code_out !== 16'hAAA7) begin n_bad++; $display("FAIL pp_hold: got %h want aaa7", code_out); end
      pop_one();
      n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty: got %b want 0", code_valid); end
   endtask

   task automatic test_reset_mid_encode();
      int w; bit ok; logic [15:0] word; int cyc; bit got; bit seen;
      code_ready = 1'b1;
      offer(8'h01, w, ok);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready_in_reset: got %b want 0", msg_ready); end
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (code_valid !== 1'b0 || busy !== 1'b0 || code_out !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_state: got v=%b busy=%b d=%h want 0/0/0000", code_valid, busy, code_out); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (code_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_push: got %b want 0", seen); end
      offer(8'hFF, w, ok);
      wait_word(word, cyc, got);
      n_cmp++; if (got !== 1'b1 || word !== 16'hAAA7) begin n_bad++; $display("FAIL rst_mid_next_word: got v=%b d=%h want 1/aaa7", got, word); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_ones_zero();
      test_back_to_back();
      test_backpressure();
      test_push_pop();
      test_reset_mid_encode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
